// File: rtl/systolic_drain.sv
// systolic_drain: result collector for the FP-INT MAC systolic array.
// Snapshots all N*N accumulator/exponent results on the rising edge of the
// array's done level, then streams them out row-major over valid/ready.
// The snapshot lets the array start its next job while results drain.
module systolic_drain #(
  parameter int ACC_WIDTH = 32,
  parameter int EXP_WIDTH = 5,
  parameter int N         = 2,
  localparam int IW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done,
  input  logic [N*N*ACC_WIDTH-1:0]   acc_in,
  input  logic [N*N*EXP_WIDTH-1:0]   exp_in,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       out_acc,
  output logic [EXP_WIDTH-1:0]       out_exp,
  output logic [IW-1:0]              out_row,
  output logic [IW-1:0]              out_col,
  output logic                       out_last,
  output logic                       busy,
  output logic                       drain_done,
  output logic                       overrun
);

  // Flat snapshot index width; the beat position is tracked as (row, col)
  // counters so no divider is needed for arbitrary N.
  localparam int SW = (N * N > 1) ? $clog2(N * N) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t               state;
  logic                 done_q;
  logic [IW-1:0]        row;
  logic [IW-1:0]        col;
  logic                 drain_done_q;
  logic                 overrun_q;
  logic [ACC_WIDTH-1:0] snap_acc [N*N];
  logic [EXP_WIDTH-1:0] snap_exp [N*N];

  logic                 done_edge;
  logic                 capture;
  logic                 transfer;
  logic                 row_end;
  logic                 col_end;
  logic                 last_beat;
  logic [SW-1:0]        sel;

  assign done_edge = done & ~done_q;
  assign capture   = (state == IDLE) & done_edge & ~flush;
  assign transfer  = (state == DRAIN) & out_ready;
  assign col_end   = (col == IW'(N - 1));
  assign row_end   = (row == IW'(N - 1));
  assign last_beat = row_end & col_end;
  assign sel       = SW'(row) * SW'(N) + SW'(col);

  // Delayed copy of done for rising-edge detection; clears to 0 so a done
  // that is already high when reset releases still looks like an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done;
    end
  end

  // Control FSM: beat counters, drain-complete pulse and sticky overrun.
  // flush outranks everything; edges seen while draining are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      drain_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (flush) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      drain_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (done_edge) begin
            state <= DRAIN;
            row   <= '0;
            col   <= '0;
          end
        end
        DRAIN: begin
          if (done_edge) begin
            overrun_q <= 1'b1;
          end
          if (transfer) begin
            if (last_beat) begin
              state        <= IDLE;
              row          <= '0;
              col          <= '0;
              drain_done_q <= 1'b1;
            end else if (col_end) begin
              col <= '0;
              row <= row + IW'(1);
            end else begin
              col <= col + IW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          row   <= '0;
          col   <= '0;
        end
      endcase
    end
  end

  // Snapshot registers: loaded only when a new drain is accepted, so the
  // array is free to change its outputs from the following cycle on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N * N; k++) begin
        snap_acc[k] <= '0;
        snap_exp[k] <= '0;
      end
    end else if (capture) begin
      for (int k = 0; k < N * N; k++) begin
        snap_acc[k] <= acc_in[k*ACC_WIDTH +: ACC_WIDTH];
        snap_exp[k] <= exp_in[k*EXP_WIDTH +: EXP_WIDTH];
      end
    end
  end

  // Outputs come straight from registers, so they are stable while the
  // downstream stalls and all read zero during reset.
  assign out_valid  = (state == DRAIN);
  assign busy       = (state == DRAIN);
  assign out_acc    = snap_acc[sel];
  assign out_exp    = snap_exp[sel];
  assign out_row    = row;
  assign out_col    = col;
  assign out_last   = (state == DRAIN) & last_beat;
  assign drain_done = drain_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: directed checks of capture, drain order, backpressure,
// snapshot isolation, overrun, flush and asynchronous reset for N=2.
module tb_systolic_drain;

  localparam int ACC_WIDTH = 32;
  localparam int EXP_WIDTH = 5;
  localparam int N         = 2;

  logic                     clk;
  logic                     rst;
  logic                     done;
  logic [N*N*ACC_WIDTH-1:0] acc_in;
  logic [N*N*EXP_WIDTH-1:0] exp_in;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_WIDTH-1:0]     out_acc;
  logic [EXP_WIDTH-1:0]     out_exp;
  logic [0:0]               out_row;
  logic [0:0]               out_col;
  logic                     out_last;
  logic                     busy;
  logic                     drain_done;
  logic                     overrun;

  int total;
  int bad;

  localparam logic [N*N*ACC_WIDTH-1:0] ACC_DATA = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [N*N*EXP_WIDTH-1:0] EXP_DATA = {5'd4, 5'd3, 5'd2, 5'd1};

  systolic_drain #(
    .ACC_WIDTH(ACC_WIDTH),
    .EXP_WIDTH(EXP_WIDTH),
    .N(N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .done(done),
    .acc_in(acc_in),
    .exp_in(exp_in),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc(out_acc),
    .out_exp(out_exp),
    .out_row(out_row),
    .out_col(out_col),
    .out_last(out_last),
    .busy(busy),
    .drain_done(drain_done),
    .overrun(overrun)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 ns after the rising edge
  task automatic applyStimulus(input logic d, input logic fl, input logic rdy);
    done      = d;
    flush     = fl;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Single comparison point
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full beat check while draining
  task automatic checkBeat(input string tag, input int a, input int e, input int r, input int c, input int l);
    checkOutput({tag, "_valid"}, 32'(out_valid), 1);
    checkOutput({tag, "_busy"},  32'(busy), 1);
    checkOutput({tag, "_acc"},   out_acc, a);
    checkOutput({tag, "_exp"},   32'(out_exp), e);
    checkOutput({tag, "_row"},   32'(out_row), r);
    checkOutput({tag, "_col"},   32'(out_col), c);
    checkOutput({tag, "_last"},  32'(out_last), l);
  endtask

  // Everything-zero check used for reset
  task automatic checkZero(input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid), 0);
    checkOutput({tag, "_busy"},  32'(busy), 0);
    checkOutput({tag, "_ddone"}, 32'(drain_done), 0);
    checkOutput({tag, "_ovr"},   32'(overrun), 0);
    checkOutput({tag, "_acc"},   out_acc, 0);
    checkOutput({tag, "_exp"},   32'(out_exp), 0);
    checkOutput({tag, "_row"},   32'(out_row), 0);
    checkOutput({tag, "_col"},   32'(out_col), 0);
    checkOutput({tag, "_last"},  32'(out_last), 0);
  endtask

  // Directed sequence
  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    done      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    acc_in    = ACC_DATA;
    exp_in    = EXP_DATA;
    #12;
    checkZero("reset");
    #2 rst = 1'b1;
    applyStimulus(0, 0, 1);
    checkOutput("idle_valid", 32'(out_valid), 0);

    $display("[TB] capture and drain");
    applyStimulus(1, 0, 1); checkBeat("t1b0", 'h11, 1, 0, 0, 0);
    applyStimulus(0, 0, 1); checkBeat("t1b1", 'h22, 2, 0, 1, 0);
    applyStimulus(0, 0, 1); checkBeat("t1b2", 'h33, 3, 1, 0, 0);
    applyStimulus(0, 0, 1); checkBeat("t1b3", 'h44, 4, 1, 1, 1);
    checkOutput("t1_ddone_early", 32'(drain_done), 0);
    applyStimulus(0, 0, 1);
    checkOutput("t1_ddone", 32'(drain_done), 1);
    checkOutput("t1_valid_end", 32'(out_valid), 0);
    checkOutput("t1_busy_end", 32'(busy), 0);
    applyStimulus(0, 0, 1);
    checkOutput("t1_ddone_pulse", 32'(drain_done), 0);

    $display("[TB] backpressure");
    applyStimulus(1, 0, 1); checkBeat("t2b0", 'h11, 1, 0, 0, 0);
    applyStimulus(0, 0, 1); checkBeat("t2b1", 'h22, 2, 0, 1, 0);
    for (int s = 0; s < 3; s++) begin
      applyStimulus(0, 0, 0); checkBeat("t2hold", 'h22, 2, 0, 1, 0);
    end
    applyStimulus(0, 0, 1); checkBeat("t2b2", 'h33, 3, 1, 0, 0);
    applyStimulus(0, 0, 1); checkBeat("t2b3", 'h44, 4, 1, 1, 1);
    applyStimulus(0, 0, 1);
    checkOutput("t2_ddone", 32'(drain_done), 1);

    $display("[TB] snapshot isolation and capture right after drain_done");
    applyStimulus(1, 0, 1); checkBeat("t3b0", 'h11, 1, 0, 0, 0);
    acc_in = {4{32'hFF}};
    exp_in = '0;
    applyStimulus(0, 0, 1); checkBeat("t3b1", 'h22, 2, 0, 1, 0);
    applyStimulus(0, 0, 1); checkBeat("t3b2", 'h33, 3, 1, 0, 0);
    applyStimulus(0, 0, 1); checkBeat("t3b3", 'h44, 4, 1, 1, 1);
    applyStimulus(0, 0, 1);
    checkOutput("t3_ddone", 32'(drain_done), 1);
    acc_in = ACC_DATA;
    exp_in = EXP_DATA;

    $display("[TB] overrun");
    applyStimulus(1, 0, 1); checkBeat("t4b0", 'h11, 1, 0, 0, 0);
    applyStimulus(0, 0, 1); checkBeat("t4b1", 'h22, 2, 0, 1, 0);
    checkOutput("t4_ovr_pre", 32'(overrun), 0);
    applyStimulus(0, 0, 1); checkBeat("t4b2", 'h33, 3, 1, 0, 0);
    applyStimulus(1, 0, 1); checkBeat("t4b3", 'h44, 4, 1, 1, 1);
    checkOutput("t4_ovr", 32'(overrun), 1);
    applyStimulus(0, 0, 1);
    checkOutput("t4_ddone", 32'(drain_done), 1);
    checkOutput("t4_ovr_sticky", 32'(overrun), 1);
    applyStimulus(0, 0, 1);
    checkOutput("t4_no_redrain", 32'(out_valid), 0);
    checkOutput("t4_ovr_sticky2", 32'(overrun), 1);

    $display("[TB] flush with coincident edge");
    applyStimulus(1, 0, 1); checkBeat("t5b0", 'h11, 1, 0, 0, 0);
    applyStimulus(0, 0, 1); checkBeat("t5b1", 'h22, 2, 0, 1, 0);
    applyStimulus(0, 0, 1); checkBeat("t5b2", 'h33, 3, 1, 0, 0);
    applyStimulus(1, 1, 1);
    checkOutput("t5_valid", 32'(out_valid), 0);
    checkOutput("t5_ovr", 32'(overrun), 0);
    checkOutput("t5_ddone", 32'(drain_done), 0);
    checkOutput("t5_busy", 32'(busy), 0);
    applyStimulus(1, 0, 1);
    checkOutput("t5_edge_ignored", 32'(out_valid), 0);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1); checkBeat("t5r0", 'h11, 1, 0, 0, 0);
    applyStimulus(0, 0, 1); checkBeat("t5r1", 'h22, 2, 0, 1, 0);
    applyStimulus(0, 0, 1); checkBeat("t5r2", 'h33, 3, 1, 0, 0);
    applyStimulus(0, 0, 1); checkBeat("t5r3", 'h44, 4, 1, 1, 1);
    applyStimulus(0, 0, 1);
    checkOutput("t5_ddone_end", 32'(drain_done), 1);
    checkOutput("t5_ovr_end", 32'(overrun), 0);

    $display("[TB] edge on last-beat transfer");
    applyStimulus(1, 0, 1); checkBeat("t6b0", 'h11, 1, 0, 0, 0);
    applyStimulus(0, 0, 1); checkBeat("t6b1", 'h22, 2, 0, 1, 0);
    applyStimulus(0, 0, 1); checkBeat("t6b2", 'h33, 3, 1, 0, 0);
    applyStimulus(0, 0, 1); checkBeat("t6b3", 'h44, 4, 1, 1, 1);
    applyStimulus(1, 0, 1);
    checkOutput("t6_ddone", 32'(drain_done), 1);
    checkOutput("t6_ovr", 32'(overrun), 1);
    checkOutput("t6_valid", 32'(out_valid), 0);
    applyStimulus(1, 0, 1);
    checkOutput("t6_dropped", 32'(out_valid), 0);

    $display("[TB] asynchronous reset mid-drain");
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 1); checkBeat("t7b0", 'h11, 1, 0, 0, 0);
    applyStimulus(1, 0, 1); checkBeat("t7b1", 'h22, 2, 0, 1, 0);
    #3 rst = 1'b0;
    #1 checkZero("t7rst");
    #2 rst = 1'b1;
    @(posedge clk);
    #1 checkBeat("t7c0", 'h11, 1, 0, 0, 0);
    applyStimulus(1, 0, 1); checkBeat("t7c1", 'h22, 2, 0, 1, 0);
    applyStimulus(1, 0, 1); checkBeat("t7c2", 'h33, 3, 1, 0, 0);
    applyStimulus(1, 0, 1); checkBeat("t7c3", 'h44, 4, 1, 1, 1);
    applyStimulus(1, 0, 1);
    checkOutput("t7_ddone", 32'(drain_done), 1);
    checkOutput("t7_valid_end", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Output-side collector for the FP-INT MAC systolic array: the reader for the array's result writer.
- On the array's `done` rising edge it snapshots all N*N accumulator and exponent results.
- It then streams the results out one per beat, row-major, over a valid/ready interface to the downstream normaliser/writeback.
- The array's outputs may change as soon as the snapshot is taken.

Parameters:
- ACC_WIDTH, 32, width of each fixed-point accumulator result
- EXP_WIDTH, 5, width of each shared exponent result
- N, 2, array dimension; N*N results per drain (N >= 1)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- done  input  1  array completion level from last PE; rising edge triggers capture
- acc_in  input  N*N*ACC_WIDTH  flattened results; PE (i,j) at bits [(i*N+j)*ACC_WIDTH +: ACC_WIDTH]
- exp_in  input  N*N*EXP_WIDTH  flattened exponents, same indexing with EXP_WIDTH
- flush  input  1  synchronous abort; returns to IDLE
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts beat
- out_acc  output  ACC_WIDTH  result value
- out_exp  output  EXP_WIDTH  result exponent
- out_row  output  max(1,clog2(N))  row index i of beat
- out_col  output  max(1,clog2(N))  column index j of beat
- out_last  output  1  high on beat idx == N*N-1
- busy  output  1  high while in DRAIN
- drain_done  output  1  one-cycle pulse after final beat accepted
- overrun  output  1  sticky: done edge seen while busy

Behaviour:
- Reset (rst low, async): state=IDLE, idx=0, done_q=0, snapshot regs=0. All outputs 0: out_valid, out_last, busy, drain_done, overrun, out_acc, out_exp, out_row, out_col.
- Edge detect: done_q <= done every cycle; edge = done & !done_q. done already high on the first cycle after reset counts as an edge.
- IDLE:
  - On edge (and flush low), latch all acc_in/exp_in into the snapshot, set idx=0, go to DRAIN.
  - out_valid rises the next cycle (1-cycle latency from edge).
- DRAIN:
  - out_valid=1 and busy=1.
  - out_acc/out_exp = snapshot[idx]; out_row = idx/N; out_col = idx%N; out_last = (idx==N*N-1).
- Handshake:
  - A beat transfers when out_valid & out_ready; idx increments on transfer.
  - While out_valid & !out_ready, all out_* stay stable. out_valid never drops without a transfer, except on flush or reset.
- Last beat: transfer with idx==N*N-1 -> IDLE next cycle, idx=0, drain_done=1 for exactly that cycle.
- N=1: a single beat with out_last=1.
- Edge during DRAIN:
  - Snapshot is not overwritten; set overrun=1 (sticky).
  - The edge is dropped, not queued.
  - An edge in the same cycle as the last-beat transfer is also dropped with overrun=1.
- Edge in the IDLE cycle right after drain_done is captured normally.
- flush:
  - Highest priority over edge and transfer: next cycle state=IDLE, idx=0, out_valid=0, overrun=0, no drain_done pulse.
  - An edge coincident with flush is ignored and does not set overrun.
- Snapshot registers are written only on capture. out_acc/out_exp show snapshot[idx] even when out_valid=0 (not guaranteed meaningful).
- No arithmetic on data; values pass through bit-exact.

Test Plan:
- Capture and drain, N=2: acc_in={PE0=0x11,PE1=0x22,PE2=0x33,PE3=0x44}, exp_in={1,2,3,4}; pulse done; out_ready=1 -> out_valid from the next cycle for 4 cycles.
  - Beats (acc,exp,row,col): (0x11,1,0,0), (0x22,2,0,1), (0x33,3,1,0), (0x44,4,1,1).
  - out_last on beat 4; drain_done pulses the cycle after beat 4; busy=0 afterwards.
- Backpressure: same data, out_ready low for 3 cycles on beat 1 -> out_acc held at 0x22, row=0, col=1, out_valid=1 throughout; total drain 7 cycles.
- Snapshot isolation: change acc_in to all 0xFF one cycle after done edge -> drained values are still 0x11..0x44.
- Overrun: second done edge while busy on beat 2 -> overrun=1 and stays 1; no second drain after the first completes.
- flush on beat 2 with simultaneous done edge -> out_valid=0 next cycle, overrun=0, no drain_done; a subsequent edge drains from idx 0.
- Reset mid-DRAIN: assert rst low asynchronously -> all outputs 0 immediately. After release with done held high -> capture occurs (edge detected) and drains normally.
